// File: rtl/output_spin_pkg.sv
// -----------------------------------------------------------------------------
// output_spin_pkg
// Shared definitions for the output spin register-file stream controller:
//   - read-side FSM state encoding
//   - beats-per-word helper (ceiling division of spin width by bus width)
//   - default word, bus and register-file sizes
// -----------------------------------------------------------------------------
package output_spin_pkg;

    localparam int SPIN_W_DEFAULT   = 50;
    localparam int GPIO_W_DEFAULT   = 8;
    localparam int RF_DEPTH_DEFAULT = 200;

    // Read side: fetch address, load data, then serialise beats.
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_LOAD  = 2'd2,
        RD_SEND  = 2'd3
    } rd_state_t;

    // Number of bus beats needed to carry one spin word.
    function automatic int calc_beats(input int spin_w, input int gpio_w);
        return (spin_w + gpio_w - 1) / gpio_w;
    endfunction

endpackage

// File: rtl/spin_word_serializer.sv
// -----------------------------------------------------------------------------
// spin_word_serializer
// Holds one spin word and presents it LSB-first as GPIO_W-wide beats on a
// valid/ready bus. The final beat is zero-padded above the word's MSB.
//
// Ports:
//   i_clk, i_rstn    clock, asynchronous active-low reset
//   clear            synchronous session clear (abandons an in-flight word)
//   load             capture load_data and start beat 0
//   load_data        word to serialise
//   out_gpio         current beat (0 when not valid)
//   out_gpio_valid   a beat is being offered
//   out_gpio_ready   receiver accepts the offered beat
//   word_done        one-cycle pulse: the last beat was accepted this cycle
// -----------------------------------------------------------------------------
module spin_word_serializer
    import output_spin_pkg::*;
#(
    parameter int SPIN_W = SPIN_W_DEFAULT,
    parameter int GPIO_W = GPIO_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              clear,
    input  logic              load,
    input  logic [SPIN_W-1:0] load_data,
    output logic [GPIO_W-1:0] out_gpio,
    output logic              out_gpio_valid,
    input  logic              out_gpio_ready,
    output logic              word_done
);

    localparam int BEATS  = calc_beats(SPIN_W, GPIO_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAD_W  = BEATS * GPIO_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [SPIN_W-1:0] hold_q;
    logic [BEAT_W-1:0] beat_q;
    logic              valid_q;
    logic [PAD_W-1:0]  padded;
    logic              beat_accept;

    // Zero-extension supplies the padding of the final beat.
    assign padded      = PAD_W'(hold_q);
    assign beat_accept = valid_q && out_gpio_ready;
    assign word_done   = beat_accept && (beat_q == LAST_BEAT);

    assign out_gpio_valid = valid_q;
    assign out_gpio       = valid_q ? padded[int'(beat_q) * GPIO_W +: GPIO_W] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            hold_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            hold_q  <= load_data;
            beat_q  <= '0;
            valid_q <= 1'b1;
        end else if (beat_accept) begin
            if (beat_q == LAST_BEAT) begin
                beat_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/output_spin_rf_stream_ctrl.sv
// -----------------------------------------------------------------------------
// output_spin_rf_stream_ctrl
// Captures per-run spin read-out words into an external single-port register
// file used as a circular buffer, and streams them out over a GPIO-width
// valid/ready bus. Either drains after final_run (conf_stream_mode=0) or
// streams while capturing (conf_stream_mode=1).
//
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   conf_sys_ctrl_reg_RESET       rising edge starts a new session
//   conf_reg_total_run_count      runs in the session
//   conf_reg_total_rerun_count    reruns in the session
//   conf_stream_mode              0 = drain after final_run, 1 = stream
//   spin_wr_valid, spin_read_out  one-cycle word capture strobe and data
//   final_run                     last run in progress or complete
//   rf_q                          RF read data, 1-cycle latency
//   rf_web, rf_a, rf_d, rf_bweb   RF port (enables active low)
//   out_gpio, out_gpio_valid,
//   out_gpio_ready                output beat handshake
//   gpio_ie, gpio_oen             pad direction (both high = input)
//   buffer_full                   RF holds RF_DEPTH words
//   overflow                      sticky: a word was dropped on a full RF
//   stream_done                   every word of the session has been sent
// -----------------------------------------------------------------------------
module output_spin_rf_stream_ctrl
    import output_spin_pkg::*;
#(
    parameter int SPIN_W   = SPIN_W_DEFAULT,
    parameter int GPIO_W   = GPIO_W_DEFAULT,
    parameter int RF_DEPTH = RF_DEPTH_DEFAULT,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 9
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              conf_sys_ctrl_reg_RESET,
    input  logic [7:0]        conf_reg_total_run_count,
    input  logic [7:0]        conf_reg_total_rerun_count,
    input  logic              conf_stream_mode,
    input  logic              spin_wr_valid,
    input  logic [SPIN_W-1:0] spin_read_out,
    input  logic              final_run,
    input  logic [SPIN_W-1:0] rf_q,
    output logic              rf_web,
    output logic [ADDR_W-1:0] rf_a,
    output logic [SPIN_W-1:0] rf_d,
    output logic [SPIN_W-1:0] rf_bweb,
    output logic [GPIO_W-1:0] out_gpio,
    output logic              out_gpio_valid,
    input  logic              out_gpio_ready,
    output logic              gpio_ie,
    output logic              gpio_oen,
    output logic              buffer_full,
    output logic              overflow,
    output logic              stream_done
);

    localparam int OCC_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RF_DEPTH - 1);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(RF_DEPTH);

    rd_state_t         state_q, state_d;
    logic              reset_q;
    logic              sess_clr;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  sent_count_q;
    logic              wbuf_valid_q;
    logic [SPIN_W-1:0] wbuf_data_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_pending;
    logic              overflow_q;
    logic              stream_done_q;
    logic              accept_wr;
    logic              drop_wr;
    logic              load;
    logic              word_done;

    // Depth need not be a power of two, so pointers wrap by explicit compare.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign sess_clr = conf_sys_ctrl_reg_RESET && !reset_q;
    assign total    = CNT_W'(conf_reg_total_run_count) + CNT_W'(conf_reg_total_rerun_count);

    // A word still sitting in the write buffer already owns an RF slot.
    assign occ_pending = occ_q + OCC_W'(wbuf_valid_q);
    assign accept_wr   = spin_wr_valid && (wr_count_q < total);
    assign drop_wr     = accept_wr && (occ_pending >= DEPTH_OCC);
    assign load        = (state_q == RD_LOAD);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            reset_q <= 1'b0;
        end else begin
            reset_q <= conf_sys_ctrl_reg_RESET;
        end
    end

    // ---------------- write side ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_count_q   <= '0;
            wbuf_valid_q <= 1'b0;
            wbuf_data_q  <= '0;
            wr_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else if (sess_clr) begin
            wr_count_q   <= '0;
            wbuf_valid_q <= 1'b0;
            wbuf_data_q  <= '0;
            wr_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept_wr) begin
                wr_count_q <= wr_count_q + CNT_W'(1);
            end
            wbuf_valid_q <= accept_wr && !drop_wr;
            if (accept_wr && !drop_wr) begin
                wbuf_data_q <= spin_read_out;
            end
            if (drop_wr) begin
                overflow_q <= 1'b1;
            end
            if (wbuf_valid_q) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
        end
    end

    // ---------------- read side ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= RD_IDLE;
        end else if (sess_clr) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can infer a latch.
        state_d = state_q;
        unique case (state_q)
            RD_IDLE: begin
                if (occ_q != '0 && (conf_stream_mode || (final_run && !wbuf_valid_q))) begin
                    state_d = RD_FETCH;
                end
            end
            // A pending write owns the port; retry the read next cycle.
            RD_FETCH: if (!wbuf_valid_q) state_d = RD_LOAD;
            RD_LOAD:  state_d = RD_SEND;
            RD_SEND: begin
                if (word_done) begin
                    state_d = (occ_q != '0) ? RD_FETCH : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            sent_count_q  <= '0;
            stream_done_q <= 1'b0;
        end else if (sess_clr) begin
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            sent_count_q  <= '0;
            stream_done_q <= 1'b0;
        end else begin
            unique case ({wbuf_valid_q, load})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
            if (load) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (word_done) begin
                sent_count_q <= sent_count_q + CNT_W'(1);
                if ((sent_count_q + CNT_W'(1)) == total) begin
                    stream_done_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- RF port: writes win over reads ----------------
    always_comb begin
        rf_web  = 1'b1;
        rf_bweb = '1;
        rf_a    = '0;
        rf_d    = '0;
        if (wbuf_valid_q) begin
            rf_web  = 1'b0;
            rf_bweb = '0;
            rf_a    = wr_ptr_q;
            rf_d    = wbuf_data_q;
        end else if (state_q == RD_FETCH) begin
            rf_a = rd_ptr_q;
        end
    end

    spin_word_serializer #(
        .SPIN_W (SPIN_W),
        .GPIO_W (GPIO_W)
    ) u_serializer (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .clear          (sess_clr),
        .load           (load),
        .load_data      (rf_q),
        .out_gpio       (out_gpio),
        .out_gpio_valid (out_gpio_valid),
        .out_gpio_ready (out_gpio_ready),
        .word_done      (word_done)
    );

    assign gpio_ie     = ~(final_run | conf_stream_mode | out_gpio_valid);
    assign gpio_oen    = ~(final_run | conf_stream_mode | out_gpio_valid);
    assign buffer_full = (occ_q == DEPTH_OCC);
    assign overflow    = overflow_q;
    assign stream_done = stream_done_q;

endmodule

// File: tb/tb_output_spin_rf_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_output_spin_rf_stream_ctrl
// Directed bench for output_spin_rf_stream_ctrl with default parameters
// (SPIN_W=50, GPIO_W=8, RF_DEPTH=200). A behavioural single-port RF with
// one-cycle read latency is attached; accepted beats are collected and
// reassembled into words for comparison with hand-chosen expected words.
// -----------------------------------------------------------------------------
module tb_output_spin_rf_stream_ctrl;

    localparam int SPIN_W = 50;
    localparam int GPIO_W = 8;
    localparam int ADDR_W = 8;
    localparam int BEATS  = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              conf_reset;
    logic [7:0]        conf_run;
    logic [7:0]        conf_rerun;
    logic              conf_mode;
    logic              spin_wr_valid;
    logic [SPIN_W-1:0] spin_read_out;
    logic              final_run;
    logic [SPIN_W-1:0] rf_q;
    logic              rf_web;
    logic [ADDR_W-1:0] rf_a;
    logic [SPIN_W-1:0] rf_d;
    logic [SPIN_W-1:0] rf_bweb;
    logic [GPIO_W-1:0] out_gpio;
    logic              out_gpio_valid;
    logic              out_gpio_ready;
    logic              gpio_ie;
    logic              gpio_oen;
    logic              buffer_full;
    logic              overflow;
    logic              stream_done;

    int n_vec = 0;
    int n_err = 0;

    logic [GPIO_W-1:0] beats[$];
    logic [SPIN_W-1:0] exp_words[$];

    always #5 clk = ~clk;

    output_spin_rf_stream_ctrl dut (
        .i_clk                      (clk),
        .i_rstn                     (rst_n),
        .conf_sys_ctrl_reg_RESET    (conf_reset),
        .conf_reg_total_run_count   (conf_run),
        .conf_reg_total_rerun_count (conf_rerun),
        .conf_stream_mode           (conf_mode),
        .spin_wr_valid              (spin_wr_valid),
        .spin_read_out              (spin_read_out),
        .final_run                  (final_run),
        .rf_q                       (rf_q),
        .rf_web                     (rf_web),
        .rf_a                       (rf_a),
        .rf_d                       (rf_d),
        .rf_bweb                    (rf_bweb),
        .out_gpio                   (out_gpio),
        .out_gpio_valid             (out_gpio_valid),
        .out_gpio_ready             (out_gpio_ready),
        .gpio_ie                    (gpio_ie),
        .gpio_oen                   (gpio_oen),
        .buffer_full                (buffer_full),
        .overflow                   (overflow),
        .stream_done                (stream_done)
    );

    // NOTE: the RF model memory is deliberately not reset, like a real SRAM;
    // locations are always written before the controller reads them.
    logic [SPIN_W-1:0] rf_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (!rf_web) rf_mem[rf_a] <= (rf_mem[rf_a] & rf_bweb) | (rf_d & ~rf_bweb);
        rf_q <= rf_mem[rf_a];
    end

    // Beats are taken from pre-edge values, i.e. exactly what the edge accepts.
    always @(posedge clk) begin
        if (rst_n && out_gpio_valid && out_gpio_ready) beats.push_back(out_gpio);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session(input logic [7:0] run, input logic [7:0] rerun, input logic mode);
        conf_run   = run;
        conf_rerun = rerun;
        conf_mode  = mode;
        conf_reset = 1'b1;
        tick(1);
        conf_reset = 1'b0;
        tick(1);
        beats.delete();
        exp_words.delete();
    endtask

    // One capture pulse; returns the RF port state in the following cycle,
    // which is the commit cycle when the word was accepted.
    task automatic pulse_word(input logic [SPIN_W-1:0] w, output logic [ADDR_W-1:0] a,
                              output logic web);
        spin_read_out = w;
        spin_wr_valid = 1'b1;
        tick(1);
        spin_wr_valid = 1'b0;
        a   = rf_a;
        web = rf_web;
        tick(2);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int cyc = 0;
        while (beats.size() < n && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check("beat_count", 64'(beats.size()), 64'(n));
    endtask

    task automatic check_stream(input string tag);
        for (int w = 0; w < exp_words.size(); w++) begin
            logic [63:0] got;
            got = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (w * BEATS + b < beats.size()) got[b*8 +: 8] = beats[w * BEATS + b];
            end
            check($sformatf("%s[%0d]", tag, w), got, 64'(exp_words[w]));
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic              web;
        logic [7:0]        exp_bp[BEATS];
        int                cyc;
        logic              seen;

        rst_n          = 1'b0;
        conf_reset     = 1'b0;
        conf_run       = '0;
        conf_rerun     = '0;
        conf_mode      = 1'b0;
        spin_wr_valid  = 1'b0;
        spin_read_out  = '0;
        final_run      = 1'b0;
        out_gpio_ready = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_rf_web",  64'(rf_web), 64'd1);
        check("rst_rf_bweb", 64'(rf_bweb), 64'h3_FFFF_FFFF_FFFF);
        check("rst_rf_a",    64'(rf_a), 64'd0);
        check("rst_rf_d",    64'(rf_d), 64'd0);
        check("rst_valid",   64'(out_gpio_valid), 64'd0);
        check("rst_gpio",    64'(out_gpio), 64'd0);
        check("rst_ie",      64'(gpio_ie), 64'd1);
        check("rst_oen",     64'(gpio_oen), 64'd1);
        check("rst_full",    64'(buffer_full), 64'd0);
        check("rst_ovf",     64'(overflow), 64'd0);
        check("rst_done",    64'(stream_done), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // ---------------- legacy drain ----------------
        out_gpio_ready = 1'b1;
        start_session(8'd3, 8'd1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            pulse_word(SPIN_W'(i), a, web);
            check($sformatf("leg_wr_web[%0d]", i), 64'(web), 64'd0);
            check($sformatf("leg_wr_a[%0d]", i), 64'(a), 64'(i - 1));
            exp_words.push_back(SPIN_W'(i));
        end
        pulse_word(50'h1_2345, a, web);
        check("leg_ignored_web", 64'(web), 64'd1);
        tick(5);
        check("leg_no_send_yet", 64'(out_gpio_valid), 64'd0);
        check("leg_oen_in",      64'(gpio_oen), 64'd1);
        final_run = 1'b1;
        tick(1);
        check("leg_oen_out",     64'(gpio_oen), 64'd0);
        wait_beats(28, 400);
        check("leg_done", 64'(stream_done), 64'd1);
        check("leg_beat0", 64'(beats[0]), 64'h01);
        for (int b = 1; b < BEATS; b++) check($sformatf("leg_beat%0d", b), 64'(beats[b]), 64'h00);
        check_stream("leg_word");
        tick(20);
        check("leg_idle_valid", 64'(out_gpio_valid), 64'd0);
        check("leg_no_extra",   64'(beats.size()), 64'd28);
        final_run = 1'b0;

        // ---------------- backpressure ----------------
        out_gpio_ready = 1'b0;
        start_session(8'd1, 8'd0, 1'b1);
        check("bp_oen_stream", 64'(gpio_oen), 64'd0);
        for (int b = 0; b < BEATS - 1; b++) exp_bp[b] = 8'hFF;
        exp_bp[BEATS-1] = 8'h03;
        pulse_word(50'h3_FFFF_FFFF_FFFF, a, web);
        seen = 1'b0;
        cyc  = 0;
        while (beats.size() < BEATS && cyc < 60) begin
            if (seen || out_gpio_valid) begin
                seen = 1'b1;
                check("bp_valid", 64'(out_gpio_valid), 64'd1);
                check($sformatf("bp_data%0d", beats.size()), 64'(out_gpio), 64'(exp_bp[beats.size()]));
            end
            out_gpio_ready = ~out_gpio_ready;
            tick(1);
            cyc++;
        end
        out_gpio_ready = 1'b1;
        tick(10);
        check("bp_beat_count", 64'(beats.size()), 64'(BEATS));
        for (int b = 0; b < BEATS && b < beats.size(); b++) begin
            check($sformatf("bp_beat%0d", b), 64'(beats[b]), 64'(exp_bp[b]));
        end
        check("bp_done", 64'(stream_done), 64'd1);

        // ---------------- full / overflow ----------------
        out_gpio_ready = 1'b0;
        start_session(8'd201, 8'd1, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            pulse_word(SPIN_W'(i) | 50'h2_0000_0000_0000, a, web);
            exp_words.push_back(SPIN_W'(i) | 50'h2_0000_0000_0000);
            if (i == 199) check("full_199", 64'(buffer_full), 64'd0);
        end
        check("full_200",     64'(buffer_full), 64'd1);
        check("ovf_before",   64'(overflow), 64'd0);
        pulse_word(50'h2_AAAA_AAAA_AAAA, a, web);
        check("ovf_drop_web", 64'(web), 64'd1);
        check("ovf_set",      64'(overflow), 64'd1);
        pulse_word(50'h1_5555_5555_5555, a, web);
        check("ovf_sticky",   64'(overflow), 64'd1);
        final_run      = 1'b1;
        out_gpio_ready = 1'b1;
        wait_beats(200 * BEATS, 2500);
        check_stream("full_word");
        check("full_drained", 64'(buffer_full), 64'd0);
        check("full_ovf_kept", 64'(overflow), 64'd1);
        check("full_not_done", 64'(stream_done), 64'd0);
        final_run = 1'b0;

        // ---------------- pointer wrap, concurrent streaming ----------------
        start_session(8'd255, 8'd0, 1'b1);
        for (int i = 0; i < 255; i++) begin
            pulse_word(SPIN_W'(i) * 50'h1_0001 + 50'd5, a, web);
            exp_words.push_back(SPIN_W'(i) * 50'h1_0001 + 50'd5);
            if (i == 199) check("wrap_wr_a199", 64'(a), 64'd199);
            if (i == 200) check("wrap_wr_a0",   64'(a), 64'd0);
        end
        wait_beats(255 * BEATS, 2500);
        check_stream("wrap_word");
        check("wrap_ovf",  64'(overflow), 64'd0);
        check("wrap_done", 64'(stream_done), 64'd1);

        // ---------------- session restart mid-send ----------------
        start_session(8'd2, 8'd0, 1'b1);
        pulse_word(50'h3_0605_0403_0201, a, web);
        pulse_word(50'h0_0000_0000_00AA, a, web);
        cyc = 0;
        while (beats.size() < 3 && cyc < 30) begin
            tick(1);
            cyc++;
        end
        check("rs_at_beat3",  64'(beats.size()), 64'd3);
        check("rs_beat3_dat", 64'(out_gpio), 64'h04);
        conf_reset = 1'b1;
        tick(1);
        conf_reset = 1'b0;
        check("rs_valid", 64'(out_gpio_valid), 64'd0);
        check("rs_occ",   64'(dut.occ_q), 64'd0);
        check("rs_ovf",   64'(overflow), 64'd0);
        check("rs_done",  64'(stream_done), 64'd0);
        tick(1);
        beats.delete();
        exp_words.delete();
        pulse_word(50'h1_1111_2222_3333, a, web);
        check("rs_new_a0", 64'(a), 64'd0);
        pulse_word(50'h0_ABCD_EF01_2345, a, web);
        exp_words.push_back(50'h1_1111_2222_3333);
        exp_words.push_back(50'h0_ABCD_EF01_2345);
        wait_beats(2 * BEATS, 100);
        check_stream("rs_word");
        check("rs_new_done", 64'(stream_done), 64'd1);

        // ---------------- write commit coinciding with LOAD ----------------
        start_session(8'd1, 8'd1, 1'b1);
        spin_read_out = 50'h0_0000_0000_0077;
        spin_wr_valid = 1'b1;
        tick(1);
        spin_wr_valid = 1'b0;
        tick(2);
        spin_read_out = 50'h1_0000_0000_0099;
        spin_wr_valid = 1'b1;
        tick(1);
        spin_wr_valid = 1'b0;
        check("sim_rf_web", 64'(rf_web), 64'd0);
        check("sim_rf_a",   64'(rf_a), 64'd1);
        check("sim_rf_d",   64'(rf_d), 64'h1_0000_0000_0099);
        check("sim_occ_pre", 64'(dut.occ_q), 64'd1);
        tick(1);
        check("sim_occ_post", 64'(dut.occ_q), 64'd1);
        check("sim_valid",    64'(out_gpio_valid), 64'd1);
        check("sim_beat0",    64'(out_gpio), 64'h77);
        exp_words.push_back(50'h0_0000_0000_0077);
        exp_words.push_back(50'h1_0000_0000_0099);
        wait_beats(2 * BEATS, 100);
        check_stream("sim_word");
        check("sim_done", 64'(stream_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
